// File: rtl/core_bus_pkg.sv
// Shared size encodings, FSM states and byte-lane helper for the core_bus_mem
// instruction/data memory slave.
package core_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Byte enables for an access; misaligned offsets still yield a mask, the
  // alignment check decides whether it is used.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << off;
      SIZE_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/core_bus_lane.sv
// Byte-lane steering for data accesses: write-data replication onto lanes,
// byte enables, read-data alignment/zero-extension and alignment checking.
module core_bus_lane
  import core_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_word,
  output logic        align_err
);

  logic [31:0] rd_shift;

  assign byte_en  = lane_mask(size, off);
  assign rd_shift = rd_raw >> {off, 3'b000};

  // Replicating the write data lets the byte enables alone pick the lanes.
  always_comb begin
    wr_word   = wr_data;
    rd_word   = 32'd0;
    align_err = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wr_word = {4{wr_data[7:0]}};
        rd_word = {24'd0, rd_shift[7:0]};
      end
      SIZE_HALF: begin
        wr_word   = {2{wr_data[15:0]}};
        rd_word   = {16'd0, rd_shift[15:0]};
        align_err = off[0];
      end
      SIZE_WORD: begin
        rd_word   = rd_shift;
        align_err = |off;
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_bus_mem.sv
// Instruction fetch ROM plus byte-addressable data RAM for core, with optional
// wait states, a busy handshake and error pulses for illegal data requests.
module core_bus_mem
  import core_bus_pkg::*;
#(
  parameter int    IMEM_AW     = 8,
  parameter int    DMEM_AW     = 8,
  parameter int    WAIT_CYCLES = 0,
  parameter string IMEM_INIT   = "",
  parameter string DMEM_INIT   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_en,
  input  logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  input  logic        ahb_rd_en,
  input  logic        ahb_wr_en,
  input  logic [31:0] ahb_addr,
  input  logic [1:0]  ahb_size,
  input  logic [31:0] ahb_wr_data,
  output logic [31:0] ahb_rd_data,
  output logic        ahb_rd_vld,
  output logic        ahb_busy,
  output logic        ahb_err
);

  localparam int         IMEM_DEPTH = 1 << IMEM_AW;
  localparam int         DMEM_DEPTH = 1 << DMEM_AW;
  localparam bit         NO_WAIT    = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, wdata_reg;
  logic [1:0]  size_reg;
  logic        rd_reg, wr_reg;
  logic [31:0] rom_data_reg, rd_data_reg;
  logic        rd_vld_reg, err_reg;

  logic        accept, commit, commit_en;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_size;
  logic        c_rd, c_wr;
  logic [DMEM_AW-1:0] c_idx;
  logic [3:0]  byte_en;
  logic [31:0] wr_word, rd_word;
  logic        align_err, range_err, c_err, rd_commit, wr_commit;
  logic        unused_rom_bits;

  assign unused_rom_bits = ^{rom_addr[31:IMEM_AW+2], rom_addr[1:0]};

  assign accept = (state_reg == IDLE) && (ahb_rd_en || ahb_wr_en);

  // Without wait states the access commits on its accept edge from the live
  // inputs; otherwise from the request captured at accept.
  assign c_addr  = NO_WAIT ? ahb_addr    : addr_reg;
  assign c_size  = NO_WAIT ? ahb_size    : size_reg;
  assign c_wdata = NO_WAIT ? ahb_wr_data : wdata_reg;
  assign c_rd    = NO_WAIT ? ahb_rd_en   : rd_reg;
  assign c_wr    = NO_WAIT ? ahb_wr_en   : wr_reg;
  assign c_idx   = c_addr[DMEM_AW+1:2];

  core_bus_lane u_lane (
    .size      (c_size),
    .off       (c_addr[1:0]),
    .wr_data   (c_wdata),
    .rd_raw    (dmem[c_idx]),
    .byte_en   (byte_en),
    .wr_word   (wr_word),
    .rd_word   (rd_word),
    .align_err (align_err)
  );

  assign range_err = |c_addr[31:DMEM_AW+2];
  assign c_err     = (c_rd && c_wr) || align_err || range_err;
  assign commit_en = commit && !rst;
  assign rd_commit = commit_en && c_rd && !c_wr;
  assign wr_commit = commit_en && c_wr && !c_err;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            commit = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= 32'd0;
      size_reg     <= SIZE_BYTE;
      wdata_reg    <= 32'd0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      rom_data_reg <= 32'd0;
      rd_data_reg  <= 32'd0;
      rd_vld_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= ahb_addr;
        size_reg  <= ahb_size;
        wdata_reg <= ahb_wr_data;
        rd_reg    <= ahb_rd_en;
        wr_reg    <= ahb_wr_en;
      end
      if (rom_en) rom_data_reg <= imem[rom_addr[IMEM_AW+1:2]];
      rd_vld_reg <= rd_commit;
      err_reg    <= commit_en && c_err;
      if (rd_commit) rd_data_reg <= c_err ? 32'd0 : rd_word;
    end
  end

  // Memory contents survive reset, so the array write has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) dmem[c_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
  end

  assign rom_data    = rom_data_reg;
  assign ahb_rd_data = rd_data_reg;
  assign ahb_rd_vld  = rd_vld_reg;
  assign ahb_busy    = (state_reg == WAIT);
  assign ahb_err     = err_reg;

endmodule
